down_counter: RTL and testbench

Loadable down-counter/timer, the counterpart to the team's enable-gated up-counter. A start value arrives over a valid/ready load handshake. The block counts down to zero on each enabled cycle, signals expiry with a one-cycle `done` pulse, and either returns to idle or auto-reloads. It sits beside the up-counter in timing and sequencing datapaths, where a programmed interval must elapse instead of an event count accumulating.

---
 rtl/down_counter_if.sv | 24 ++
 rtl/down_counter.sv | 82 ++++++++
 tb/tb_down_counter.sv | 241 ++++++++++++++++++++++++
 3 files changed

// File: rtl/down_counter_if.sv
// Load handshake, count controls and status outputs of the down-counter.
interface down_counter_if #(
  parameter int unsigned WIDTH = 4
);
  logic             load_valid;
  logic [WIDTH-1:0] load_val;
  logic             load_ready;
  logic             en;
  logic             auto_reload;
  logic             abort;
  logic [WIDTH-1:0] val_out;
  logic             busy;
  logic             done;

  modport master (
    output load_valid, load_val, en, auto_reload, abort,
    input  load_ready, val_out, busy, done
  );

  modport slave (
    input  load_valid, load_val, en, auto_reload, abort,
    output load_ready, val_out, busy, done
  );
endinterface

// File: rtl/down_counter.sv
// Loadable down-counter/timer: counts a programmed interval down to zero on enabled
// cycles, pulses done on expiry, and either returns to idle or reloads.
module down_counter #(
  parameter int unsigned WIDTH = 4
) (
  input  logic          clk,
  input  logic          reset,
  down_counter_if.slave bus
);

  typedef enum logic {StIdle, StRun} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic [WIDTH-1:0] reload_val_q, reload_val_d;
  logic             done_q, done_d;

  // Next-state: load acceptance in idle, abort/terminal-tick/decrement in run.
  always_comb begin
    state_d      = state_q;
    count_d      = count_q;
    reload_val_d = reload_val_q;
    done_d       = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (bus.load_valid) begin
          count_d      = bus.load_val;
          reload_val_d = bus.load_val;
          if (bus.load_val != '0) begin
            state_d = StRun;
          end else begin
            // Zero-length interval expires immediately.
            done_d = 1'b1;
          end
        end
      end
      StRun: begin
        if (bus.abort) begin
          // Abort wins over a simultaneous terminal tick; count freezes.
          state_d = StIdle;
        end else if (bus.en) begin
          if (count_q == WIDTH'(1)) begin
            done_d = 1'b1;
            if (bus.auto_reload) begin
              count_d = reload_val_q;
            end else begin
              count_d = '0;
              state_d = StIdle;
            end
          end else if (count_q > WIDTH'(1)) begin
            count_d = count_q - WIDTH'(1);
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State registers with asynchronous active-low clear.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= StIdle;
      count_q      <= '0;
      reload_val_q <= '0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      count_q      <= count_d;
      reload_val_q <= reload_val_d;
      done_q       <= done_d;
    end
  end

  // Status outputs decoded straight from state, no extra latency.
  always_comb begin
    bus.load_ready = (state_q == StIdle);
    bus.busy       = (state_q == StRun);
    bus.done       = done_q;
    bus.val_out    = count_q;
  end

endmodule

// File: tb/tb_down_counter.sv
// Self-checking bench for down_counter: directed vector table, hand-written corner
// sequences, then randomized traffic against a tick-counting reference model.
module tb_down_counter;

  localparam int unsigned W = 4;

  typedef struct {
    logic         lv;
    logic [W-1:0] lval;
    logic         en;
    logic         ar;
    logic         ab;
    int           exp_val;
    bit           exp_busy;
    bit           exp_done;
    bit           exp_ready;
  } vec_t;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_fail;
  vec_t vecs[$];

  down_counter_if #(.WIDTH(W)) dif ();

  down_counter #(.WIDTH(W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (dif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic check_all(input string tag, input int v, input bit b, input bit d,
                           input bit r);
    check({tag, ".val_out"}, int'(dif.val_out), v);
    check({tag, ".busy"}, int'(dif.busy), int'(b));
    check({tag, ".done"}, int'(dif.done), int'(d));
    check({tag, ".load_ready"}, int'(dif.load_ready), int'(r));
  endtask

  task automatic drive(input logic lv, input logic [W-1:0] lval, input logic en,
                       input logic ar, input logic ab);
    dif.load_valid  = lv;
    dif.load_val    = lval;
    dif.en          = en;
    dif.auto_reload = ar;
    dif.abort       = ab;
  endtask

  // Advance one clock and sample 1 time unit after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic add(input logic lv, input int lval, input logic en, input logic ar,
                     input logic ab, input int v, input bit b, input bit d, input bit r);
    vec_t t;
    t.lv = lv; t.lval = W'(lval); t.en = en; t.ar = ar; t.ab = ab;
    t.exp_val = v; t.exp_busy = b; t.exp_done = d; t.exp_ready = r;
    vecs.push_back(t);
  endtask

  task automatic do_reset();
    drive(1'b0, '0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    #1;
  endtask

  // Reference model state: remaining ticks, last loaded value, running flag.
  int m_cnt;
  int m_rel;
  bit m_run;
  bit m_done;

  task automatic model_step(input bit lv, input int lval, input bit en, input bit ar,
                            input bit ab);
    m_done = 1'b0;
    if (!m_run) begin
      if (lv) begin
        m_cnt = lval;
        m_rel = lval;
        if (lval == 0) m_done = 1'b1;
        else m_run = 1'b1;
      end
    end else if (ab) begin
      m_run = 1'b0;
    end else if (en) begin
      m_cnt = m_cnt - 1;
      if (m_cnt == 0) begin
        m_done = 1'b1;
        if (ar) m_cnt = m_rel;
        else m_run = 1'b0;
      end
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    reset    = 1'b1;
    drive(1'b0, '0, 1'b0, 1'b0, 1'b0);
    #2;
    reset = 1'b0;
    #1;
    check_all("reset", 0, 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    reset = 1'b1;
    #1;

    // Load 3, free-running count, no reload.
    add(1, 3, 1, 0, 0, 3, 1, 0, 0);
    add(0, 0, 1, 0, 0, 2, 1, 0, 0);
    add(0, 0, 1, 0, 0, 1, 1, 0, 0);
    add(0, 0, 1, 0, 0, 0, 0, 1, 1);
    add(0, 0, 1, 0, 0, 0, 0, 0, 1);
    // Zero load: immediate done, never busy.
    add(1, 0, 1, 0, 0, 0, 0, 1, 1);
    add(0, 0, 1, 0, 0, 0, 0, 0, 1);
    // Load 2 with auto-reload, then drop reload before the last terminal tick.
    add(1, 2, 1, 1, 0, 2, 1, 0, 0);
    add(0, 0, 1, 1, 0, 1, 1, 0, 0);
    add(0, 0, 1, 1, 0, 2, 1, 1, 0);
    add(0, 0, 1, 1, 0, 1, 1, 0, 0);
    add(0, 0, 1, 1, 0, 2, 1, 1, 0);
    add(0, 0, 1, 0, 0, 1, 1, 0, 0);
    add(0, 0, 1, 0, 0, 0, 0, 1, 1);
    // Abort at count 1 with en; load_valid held through RUN.
    add(1, 2, 1, 0, 0, 2, 1, 0, 0);
    add(1, 9, 1, 0, 0, 1, 1, 0, 0);
    add(1, 9, 1, 0, 1, 1, 0, 0, 1);
    add(1, 9, 0, 0, 0, 9, 1, 0, 0);
    add(0, 0, 0, 0, 1, 9, 0, 0, 1);
    add(0, 0, 1, 0, 1, 9, 0, 0, 1);
    // Load 5 with en toggling.
    add(1, 5, 0, 0, 0, 5, 1, 0, 0);
    add(0, 0, 1, 0, 0, 4, 1, 0, 0);
    add(0, 0, 0, 0, 0, 4, 1, 0, 0);
    add(0, 0, 1, 0, 0, 3, 1, 0, 0);
    add(0, 0, 0, 0, 0, 3, 1, 0, 0);
    add(0, 0, 1, 0, 0, 2, 1, 0, 0);
    add(0, 0, 0, 0, 0, 2, 1, 0, 0);
    add(0, 0, 1, 0, 0, 1, 1, 0, 0);
    add(0, 0, 0, 0, 0, 1, 1, 0, 0);
    add(0, 0, 1, 0, 0, 0, 0, 1, 1);
    add(0, 0, 0, 0, 0, 0, 0, 0, 1);

    foreach (vecs[i]) begin
      drive(vecs[i].lv, vecs[i].lval, vecs[i].en, vecs[i].ar, vecs[i].ab);
      step();
      check_all($sformatf("vec%0d", i), vecs[i].exp_val, vecs[i].exp_busy,
                vecs[i].exp_done, vecs[i].exp_ready);
    end

    // Maximum load: 15 enabled ticks to expiry.
    drive(1'b1, 4'd15, 1'b1, 1'b0, 1'b0);
    step();
    check_all("max.load", 15, 1'b1, 1'b0, 1'b0);
    drive(1'b0, '0, 1'b1, 1'b0, 1'b0);
    for (int i = 14; i >= 1; i--) begin
      step();
      check_all($sformatf("max.tick%0d", i), i, 1'b1, 1'b0, 1'b0);
    end
    step();
    check_all("max.expire", 0, 1'b0, 1'b1, 1'b1);

    // Async reset mid-count.
    drive(1'b1, 4'd6, 1'b1, 1'b0, 1'b0);
    step();
    drive(1'b0, '0, 1'b1, 1'b0, 1'b0);
    step();
    check_all("pre_rst", 5, 1'b1, 1'b0, 1'b0);
    #2;
    reset = 1'b0;
    #1;
    check_all("async_rst", 0, 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    reset = 1'b1;
    drive(1'b1, 4'd4, 1'b1, 1'b0, 1'b0);
    step();
    check_all("post_rst.load", 4, 1'b1, 1'b0, 1'b0);
    drive(1'b0, '0, 1'b1, 1'b0, 1'b0);
    for (int i = 3; i >= 1; i--) begin
      step();
      check_all($sformatf("post_rst.tick%0d", i), i, 1'b1, 1'b0, 1'b0);
    end
    step();
    check_all("post_rst.expire", 0, 1'b0, 1'b1, 1'b1);

    // Async reset clears a pending done pulse.
    drive(1'b1, 4'd0, 1'b0, 1'b0, 1'b0);
    step();
    check("pend_done.before", int'(dif.done), 1);
    #2;
    reset = 1'b0;
    #1;
    check("pend_done.cleared", int'(dif.done), 0);
    @(negedge clk);
    reset = 1'b1;

    // Randomized traffic against the reference model.
    do_reset();
    m_cnt = 0; m_rel = 0; m_run = 1'b0; m_done = 1'b0;
    for (int i = 0; i < 600; i++) begin
      bit lv, en, ar, ab;
      int lval;
      lv = ($urandom_range(0, 3) != 0);
      en = ($urandom_range(0, 3) != 0);
      ar = ($urandom_range(0, 2) == 0);
      ab = ($urandom_range(0, 19) == 0);
      case ($urandom_range(0, 5))
        0: lval = 0;
        1: lval = 1;
        2: lval = 15;
        default: lval = int'($urandom_range(0, 15));
      endcase
      drive(lv, W'(lval), en, ar, ab);
      model_step(lv, lval, en, ar, ab);
      step();
      check_all($sformatf("rnd%0d", i), m_cnt, m_run, m_done, !m_run);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
